msg_word_assembler: RTL and testbench
=====================================

Name: msg_word_assembler

Overview:
- Upstream feeder for the message/nonce register bank of the miner datapath.
- Accepts a byte stream from the host link and packs bytes big-endian into 32-bit words.
- Presents each word with a word index and valid/ready handshake; the consumer uses the handshake as register write-enable and the word as register d.
- Flags completion of a 16-word (512-bit) SHA-256 block.
- Discards partial words after an inter-byte timeout.

Parameters:
- WORDS_PER_BLOCK, 16, words per message block; out_idx wraps after WORDS_PER_BLOCK-1.
- IDX_W, 4, width of out_idx; must equal $clog2(WORDS_PER_BLOCK).
- TIMEOUT_CYCLES, 1000, idle cycles allowed between bytes of a partial word before it is discarded; minimum 2.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- in_data  in  8  incoming byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a byte this cycle.
- out_word  out  32  assembled word; first byte received sits in [31:24].
- out_idx  out  IDX_W  word position within the block.
- out_valid  out  1  out_word/out_idx valid.
- out_ready  in  1  consumer takes the word this cycle.
- block_done  out  1  one-cycle pulse after the last word of a block is taken.
- timeout_err  out  1  one-cycle pulse when a partial word is discarded.

Behaviour:
- Reset: clk is the only clock; clr_n is asynchronous, active-low.
  - While clr_n=0: all outputs are 0, state=FILL, byte count=0, word index=0, timer=0.
  - in_ready is registered and rises on the first clk edge after clr_n deasserts.
  - Reset mid-word or mid-hold drops all buffered data; no pulses are emitted.
- Byte acceptance: a byte is taken when in_valid & in_ready at a clk edge.
  - Byte k (k=0..3) is written to shift position [31-8k:24-8k].
  - Byte count increments 0→1→2→3.
- State FILL: in_ready=1, out_valid=0.
  - On acceptance of byte 3: out_word is loaded with the complete word and out_idx with the current index.
  - On the same edge: out_valid←1, in_ready←0, state←HOLD.
  - Latency: 4th byte edge → out_valid high immediately after that edge.
- State HOLD: in_ready=0; out_word and out_idx are held stable.
  - On out_valid & out_ready: out_valid←0, in_ready←1, byte count←0, state←FILL.
  - Index increments on the same edge, wrapping WORDS_PER_BLOCK-1→0.
  - If the taken word had out_idx=WORDS_PER_BLOCK-1, block_done=1 for exactly the following cycle.
  - out_ready while out_valid=0 is ignored.
- Throughput: at most one word per 5 cycles (4 accept cycles plus 1 hold cycle with out_ready already high).
- Timeout: applies only in FILL with byte count 1..3.
  - The timer increments each cycle with no accepted byte; it clears on any accepted byte.
  - When the timer reaches TIMEOUT_CYCLES-1 and no byte is accepted that cycle: byte count←0, timer←0, timeout_err=1 for the next cycle.
  - The word index is unchanged and out_valid is not affected.
  - A byte arriving on the same edge the timer would expire is accepted and no timeout occurs.
- Timer is inactive (held 0) at byte count 0 and in HOLD.
- Word index is never reset except by clr_n: a timeout does not restart the block.

Decomposition:
- Shared package miner_pkg holds:
  - BYTES_PER_WORD=4 and WORDS_PER_BLOCK=16.
  - State encoding (FILL=1'b0, HOLD=1'b1).
  - Byte-lane constant for big-endian packing, reused by the hash-result serializer.
- One sub-module, idle_timer.
  - Ports: clk, clr_n, run, clear, expire.
  - Function: parameterised saturating counter producing the expire strobe.
  - Reusable later for the host-link receive watchdog.

Test Plan:
- Reset then bytes 0x01,0x02,0x03,0x04 on consecutive cycles, out_ready=1 → out_word=0x01020304, out_idx=0, out_valid high one cycle, in_ready low that cycle.
- 16 words streamed, out_ready=1 → out_idx 0..15 in order, block_done one-cycle pulse after word 15 handshake, 17th word has out_idx=0.
- Word complete with out_ready=0 for 10 cycles while in_valid=1 with changing in_data → out_word stable, in_ready=0, no bytes consumed; word taken on the first cycle out_ready=1.
- TIMEOUT_CYCLES=8: send 0xAA,0xBB then idle 8 cycles → timeout_err pulse. Then 0x11,0x22,0x33,0x44 → out_word=0x11223344 with unchanged out_idx.
- Byte arrives exactly on the expiry cycle → no timeout_err, byte counted.
- clr_n low during HOLD with out_valid=1 → out_valid, in_ready, out_idx immediately 0. After release, a fresh 4-byte word gets out_idx=0.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared constants and types for the miner message datapath.
// Holds word geometry, the assembler state encoding and big-endian lane helpers.
package miner_pkg;

  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_WORD  = 4;
  localparam int WORDS_PER_BLOCK = 16;
  localparam int WORD_W          = BYTE_W * BYTES_PER_WORD;

  // Big-endian: byte 0 of a word lands in the top lane.
  localparam int LANE0_LSB = WORD_W - BYTE_W;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } asm_state_e;

  function automatic logic [4:0] lane_lsb(input logic [1:0] k);
    return 5'(LANE0_LSB - BYTE_W * int'(k));
  endfunction

endpackage

// File: rtl/msg_word_assembler_if.sv
// Byte-in / word-out handshake bundle of the message word assembler.
// master is the assembler side, slave is the host/consumer side.
interface msg_word_assembler_if #(
  parameter int IDX_W = 4
);
  import miner_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] out_word;
  logic [IDX_W-1:0]  out_idx;
  logic              out_valid;
  logic              out_ready;
  logic              block_done;
  logic              timeout_err;

  modport master (
    input  in_data, in_valid, out_ready,
    output in_ready, out_word, out_idx,
    output out_valid, block_done, timeout_err
  );

  modport slave (
    output in_data, in_valid, out_ready,
    input  in_ready, out_word, out_idx,
    input  out_valid, block_done, timeout_err
  );

endinterface

// File: rtl/msg_word_assembler_timer.sv
// Saturating idle counter; expire strobes on the last allowed idle cycle.
// Also intended for the host-link receive watchdog.
module idle_timer #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  assign expire = run && (cnt == LAST);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/msg_word_assembler.sv
// Packs a host byte stream big-endian into 32-bit message words with
// a block word index, block-done pulse and partial-word idle timeout.
module msg_word_assembler #(
  parameter int WORDS_PER_BLOCK = 16,
  parameter int IDX_W           = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input logic                  clk,
  input logic                  clr_n,
  msg_word_assembler_if.master bus
);
  import miner_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  asm_state_e        state, state_n;
  logic [1:0]        cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [WORD_W-1:0] shift, shift_n, merged;
  logic [WORD_W-1:0] word_n;
  logic [IDX_W-1:0]  oidx_n;
  logic              valid_n, rdy_n;
  logic              done_n, terr_n;
  logic              take, active, expire;

  assign take   = bus.in_valid && bus.in_ready;
  assign active = (state == FILL) && (cnt != 2'd0);

  idle_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .clr_n (clr_n),
    .run   (active && !take),
    .clear (!active || take || expire),
    .expire(expire)
  );

  always_comb begin
    merged = shift;
    merged[lane_lsb(cnt) +: BYTE_W] = bus.in_data;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    word_n  = bus.out_word;
    oidx_n  = bus.out_idx;
    valid_n = bus.out_valid;
    rdy_n   = bus.in_ready;
    done_n  = 1'b0;
    terr_n  = 1'b0;
    unique case (1'b1)
      (state == FILL): begin
        rdy_n = 1'b1;
        if (take) begin
          shift_n = merged;
          if (cnt == 2'd3) begin
            word_n  = merged;
            oidx_n  = idx;
            valid_n = 1'b1;
            rdy_n   = 1'b0;
            state_n = HOLD;
          end else begin
            cnt_n = cnt + 2'd1;
          end
        end else if (expire) begin
          cnt_n  = 2'd0;
          terr_n = 1'b1;
        end
      end
      (state == HOLD): begin
        if (bus.out_valid && bus.out_ready) begin
          valid_n = 1'b0;
          rdy_n   = 1'b1;
          cnt_n   = 2'd0;
          state_n = FILL;
          idx_n   = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
          done_n  = (bus.out_idx == LAST_IDX);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state           <= FILL;
      cnt             <= 2'd0;
      idx             <= '0;
      shift           <= '0;
      bus.out_word    <= '0;
      bus.out_idx     <= '0;
      bus.out_valid   <= 1'b0;
      bus.in_ready    <= 1'b0;
      bus.block_done  <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      idx             <= idx_n;
      shift           <= shift_n;
      bus.out_word    <= word_n;
      bus.out_idx     <= oidx_n;
      bus.out_valid   <= valid_n;
      bus.in_ready    <= rdy_n;
      bus.block_done  <= done_n;
      bus.timeout_err <= terr_n;
    end
  end

endmodule

// File: tb/tb_msg_word_assembler.sv
// Bench for msg_word_assembler: vector table, directed corner sequences
// and random traffic against a queue-based transaction model.
module tb_msg_word_assembler;

  localparam int TO  = 8;
  localparam int WPB = 16;

  logic clk;
  logic clr_n;

  msg_word_assembler_if #(.IDX_W(4)) bus ();

  msg_word_assembler #(
    .WORDS_PER_BLOCK(WPB),
    .IDX_W          (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: bytes of the pending word, held word, block position.
  logic [7:0]  q[$];
  int          idle;
  int          blk;
  bit          m_rdy, m_valid, m_done, m_terr;
  logic [31:0] m_word;
  int          m_idx;

  typedef struct {
    bit          v;
    logic [7:0]  d;
    bit          r;
    bit          e_valid;
    logic [31:0] e_word;
    logic [3:0]  e_idx;
    bit          e_rdy;
    bit          e_done;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    idle    = 0;
    blk     = 0;
    m_rdy   = 0;
    m_valid = 0;
    m_done  = 0;
    m_terr  = 0;
    m_word  = 0;
    m_idx   = 0;
  endtask

  task automatic model_step(bit v, logic [7:0] d, bit r);
    bit acc;
    acc    = v && m_rdy;
    m_done = 0;
    m_terr = 0;
    if (m_valid) begin
      if (r) begin
        m_valid = 0;
        m_done  = (m_idx == WPB - 1);
        blk     = (blk + 1) % WPB;
      end
    end else if (acc) begin
      q.push_back(d);
      idle = 0;
      if (q.size() == 4) begin
        m_word  = {q[0], q[1], q[2], q[3]};
        m_idx   = blk;
        m_valid = 1;
        q.delete();
      end
    end else if (q.size() != 0) begin
      idle++;
      if (idle == TO) begin
        q.delete();
        idle   = 0;
        m_terr = 1;
      end
    end
    m_rdy = !m_valid;
  endtask

  task automatic cmp_model();
    chk("m_in_ready", 32'(bus.in_ready), 32'(m_rdy));
    chk("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("m_block_done", 32'(bus.block_done), 32'(m_done));
    chk("m_timeout_err", 32'(bus.timeout_err), 32'(m_terr));
    if (m_valid) begin
      chk("m_out_word", bus.out_word, m_word);
      chk("m_out_idx", 32'(bus.out_idx), 32'(m_idx));
    end
  endtask

  task automatic tick(bit v, logic [7:0] d, bit r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    model_step(v, d, r);
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic send4(logic [31:0] w, bit r);
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, w[31-8*k -: 8], r);
    end
  endtask

  task automatic do_reset();
    clr_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_idx", 32'(bus.out_idx), 0);
    chk("rst_out_word", bus.out_word, 0);
    chk("rst_done_terr", 32'({bus.block_done, bus.timeout_err}), 0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
    chk("rst_rdy_rise", 32'(bus.in_ready), 1);
  endtask

  initial begin
    clr_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    tbl[0] = '{1, 8'h01, 1, 0, 32'h0, 4'd0, 1, 0};
    tbl[1] = '{1, 8'h02, 1, 0, 32'h0, 4'd0, 1, 0};
    tbl[2] = '{1, 8'h03, 1, 0, 32'h0, 4'd0, 1, 0};
    tbl[3] = '{1, 8'h04, 1, 1, 32'h01020304, 4'd0, 0, 0};
    tbl[4] = '{0, 8'h00, 1, 0, 32'h01020304, 4'd0, 1, 0};

    // First word through the vector table.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d_rdy", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_done", i), 32'(bus.block_done), 32'(tbl[i].e_done));
      chk($sformatf("vec%0d_idx", i), 32'(bus.out_idx), 32'(tbl[i].e_idx));
      if (i >= 3) chk($sformatf("vec%0d_word", i), bus.out_word, tbl[i].e_word);
    end

    // Full block plus one word: index order, wrap, block_done.
    do_reset();
    for (int w = 0; w < 17; w++) begin
      send4(32'h5A000000 + 32'(w), 1'b1);
      chk("blk_idx", 32'(bus.out_idx), 32'(w % 16));
      tick(1'b0, 8'h00, 1'b1);
      chk("blk_done", 32'(bus.block_done), 32'(w == 15));
    end

    // Back-pressure: word held, bytes refused.
    send4(32'hC0C1C2C3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 8'($urandom), 1'b0);
      chk("hold_word", bus.out_word, 32'hC0C1C2C3);
      chk("hold_rdy", 32'(bus.in_ready), 0);
    end
    tick(1'b1, 8'h55, 1'b1);
    chk("hold_taken", 32'(bus.out_valid), 0);
    send4(32'h10203040, 1'b0);
    chk("hold_next", bus.out_word, 32'h10203040);
    tick(1'b0, 8'h00, 1'b1);

    // Timeout discards a partial word but keeps the index.
    do_reset();
    send4(32'hDEADBEEF, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'hAA, 1'b0);
    tick(1'b1, 8'hBB, 1'b0);
    for (int i = 1; i <= TO; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      chk("to_terr", 32'(bus.timeout_err), 32'(i == TO));
    end
    send4(32'h11223344, 1'b0);
    chk("to_word", bus.out_word, 32'h11223344);
    chk("to_idx", 32'(bus.out_idx), 1);
    tick(1'b0, 8'h00, 1'b1);

    // Byte on the expiry cycle is kept.
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b1, 8'h02, 1'b0);
    for (int i = 0; i < TO - 1; i++) tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h03, 1'b0);
    chk("exp_no_terr", 32'(bus.timeout_err), 0);
    tick(1'b1, 8'h04, 1'b0);
    chk("exp_word", bus.out_word, 32'h01020304);
    chk("exp_idx", 32'(bus.out_idx), 2);

    // Reset while holding a word.
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    do_reset();
    send4(32'hCAFEF00D, 1'b0);
    chk("post_rst_idx", 32'(bus.out_idx), 0);
    chk("post_rst_word", bus.out_word, 32'hCAFEF00D);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int j = 0; j < 10; j++) tick(1'b0, 8'h00, 1'($urandom_range(0, 1)));
      end else begin
        tick(($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
